// File: rtl/dot11_ant_select_n.sv
// rtl/dot11_ant_select_n.sv - N-antenna RX selector: RSSI argmax with hysteresis, dwell and packet lock.
// Optional ANT_SEL_RSSI_AVG_EN: 4-tap moving average of each antenna's RSSI feeds the selection.
module dot11_ant_select_n #(
  parameter int NUM_ANT  = 4,
  parameter int ANT_W    = 3,
  parameter int RSSI_W   = 11,
  parameter int SAMPLE_W = 32,
  parameter int HYST     = 6,
  parameter int DWELL    = 64
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic [NUM_ANT*RSSI_W-1:0]    rssi_half_db,
  input  logic [NUM_ANT*SAMPLE_W-1:0]  sample_in,
  input  logic                         sample_in_strobe,
  input  logic                         rx_busy,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_out_strobe,
  output logic [ANT_W-1:0]             ant_select,
  output logic                         switch_stb,
  output logic [1:0]                   sel_state
);

  typedef enum logic [1:0] {
    S_TRACK = 2'd0,
    S_HOLD  = 2'd1,
    S_LOCK  = 2'd2
  } sel_state_t;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [RSSI_W:0]   HYST_X     = (RSSI_W + 1)'(HYST);

  sel_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ANT_W-1:0]  ant_q, ant_d;
  logic              stb_d;
  logic              go;

  logic [RSSI_W-1:0]   rssi_eff [NUM_ANT];
  logic [ANT_W-1:0]    best_idx;
  logic [RSSI_W-1:0]   best_val;
  logic [RSSI_W-1:0]   cur_val;
  logic                sw_cond;
  logic [SAMPLE_W-1:0] sample_sel;

  assign go = enable & sample_in_strobe;

`ifdef ANT_SEL_RSSI_AVG_EN
  // Window is the current strobe's RSSI plus the three previous strobed values.
  logic [RSSI_W-1:0] hist_q  [NUM_ANT][3];
  logic [RSSI_W+1:0] avg_sum [NUM_ANT];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_ANT; k++) begin
        for (int t = 0; t < 3; t++) begin
          hist_q[k][t] <= '0;
        end
      end
    end else if (go) begin
      for (int k = 0; k < NUM_ANT; k++) begin
        hist_q[k][0] <= rssi_half_db[k*RSSI_W +: RSSI_W];
        hist_q[k][1] <= hist_q[k][0];
        hist_q[k][2] <= hist_q[k][1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_ANT; k++) begin
      avg_sum[k]  = (RSSI_W + 2)'(rssi_half_db[k*RSSI_W +: RSSI_W])
                  + (RSSI_W + 2)'(hist_q[k][0])
                  + (RSSI_W + 2)'(hist_q[k][1])
                  + (RSSI_W + 2)'(hist_q[k][2]);
      rssi_eff[k] = avg_sum[k][RSSI_W+1:2];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_ANT; k++) begin
      rssi_eff[k] = rssi_half_db[k*RSSI_W +: RSSI_W];
    end
  end
`endif

  // Strict greater-than keeps the lowest index on ties; the extra bit stops cur+HYST wrapping.
  always_comb begin
    best_idx = '0;
    best_val = rssi_eff[0];
    cur_val  = rssi_eff[0];
    for (int k = 1; k < NUM_ANT; k++) begin
      if (rssi_eff[k] > best_val) begin
        best_val = rssi_eff[k];
        best_idx = ANT_W'(k);
      end
    end
    for (int k = 0; k < NUM_ANT; k++) begin
      if (ant_q == ANT_W'(k)) cur_val = rssi_eff[k];
    end
    sw_cond = {1'b0, best_val} > ({1'b0, cur_val} + HYST_X);
  end

  always_comb begin
    sample_sel = sample_in[SAMPLE_W-1:0];
    for (int k = 0; k < NUM_ANT; k++) begin
      if (ant_q == ANT_W'(k)) sample_sel = sample_in[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ant_d   = ant_q;
    stb_d   = 1'b0;
    if (go) begin
      case (state_q)
        S_TRACK: begin
          if (rx_busy) begin
            state_d = S_LOCK;
          end else if (sw_cond) begin
            ant_d   = best_idx;
            stb_d   = 1'b1;
            cnt_d   = DWELL_LOAD;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (rx_busy)            state_d = S_LOCK;
          else if (cnt_q == '0)   state_d = S_TRACK;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        S_LOCK: begin
          if (!rx_busy) state_d = S_TRACK;
        end
        default: state_d = S_TRACK;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q           <= S_TRACK;
      cnt_q             <= '0;
      ant_q             <= '0;
      switch_stb        <= 1'b0;
      sample_out_strobe <= 1'b0;
      sample_out        <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      ant_q             <= ant_d;
      switch_stb        <= stb_d;
      sample_out_strobe <= go;
      if (go) sample_out <= sample_sel;
    end
  end

  assign ant_select = ant_q;
  assign sel_state  = state_q;

endmodule
